seq_alu_core: RTL

Parametrised, registered successor to the team's combinational 8-bit add/AND datapath. It adds a full op set, an accumulator, optional unsigned saturation and a multi-cycle shift-add multiplier. Operands enter and results leave through valid/ready handshakes. It sits between the pad-level input registers and the output mux of a tile top.

---
 rtl/seq_alu_core.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_alu_core.sv
// rtl/seq_alu_core.sv - registered ALU core with accumulator, unsigned saturation and shift-add multiplier
module seq_alu_core #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t               state, state_nxt;
    logic                 accept, is_mul, mul_last;
    logic [2*WIDTH-1:0]   mcand, prod, prod_nxt;
    logic [WIDTH-1:0]     mplier, acc, acc_nxt, alu_y;
    logic [CW-1:0]        cnt;
    logic                 sat_q, alu_c, alu_o;
    logic [WIDTH:0]       add_r, sub_r, acc_r;

    assign is_mul   = MUL_EN && (op == 3'b110);
    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt == CW'(WIDTH - 1));
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                busy = 1'b1;
                if (mul_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign add_r = {1'b0, a} + {1'b0, b};
    assign sub_r = {1'b0, a} - {1'b0, b};
    assign acc_r = {1'b0, acc} + {1'b0, a};

    // Op 110 falls into the ADD arm; with the multiplier present this result is never used.
    always_comb begin
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        acc_nxt = acc;
        case (op)
            3'b000, 3'b110: begin
                alu_c = add_r[WIDTH];
                alu_o = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
                alu_y = (sat_en && alu_c) ? '1 : add_r[WIDTH-1:0];
            end
            3'b001: begin
                alu_c = sub_r[WIDTH];
                alu_o = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
                alu_y = (sat_en && alu_c) ? '0 : sub_r[WIDTH-1:0];
            end
            3'b010: alu_y = a & b;
            3'b011: alu_y = a | b;
            3'b100: alu_y = a ^ b;
            3'b101: begin
                alu_c   = acc_r[WIDTH];
                alu_o   = (acc[WIDTH-1] == a[WIDTH-1]) && (acc_r[WIDTH-1] != a[WIDTH-1]);
                alu_y   = (sat_en && alu_c) ? '1 : acc_r[WIDTH-1:0];
                acc_nxt = alu_y;
            end
            default: acc_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y      <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            sat_q <= sat_en;
            if (is_mul) begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                prod   <= '0;
                cnt    <= '0;
            end else begin
                y     <= alu_y;
                carry <= alu_c;
                ovf   <= alu_o;
                acc   <= acc_nxt;
            end
        end else if (state == S_MUL) begin
            prod   <= prod_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            // Last iteration publishes straight from prod_nxt so DONE follows without an extra cycle.
            if (mul_last) begin
                y     <= (sat_q && |prod_nxt[2*WIDTH-1:WIDTH]) ? '1 : prod_nxt[WIDTH-1:0];
                carry <= 1'b0;
                ovf   <= |prod_nxt[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule
